// File: rtl/bitwise_logic_pkg.sv
// bitwise_logic_pkg: op codes and FSM states shared by the bitwise logic unit
// Contents: op_t (3-bit operation codes), state_t (accumulate FSM states)
package bitwise_logic_pkg;
    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOR    = 3'b011,
        OP_NAND   = 3'b100,
        OP_XNOR   = 3'b101,
        OP_NOT_A  = 3'b110,
        OP_ACC_OR = 3'b111
    } op_t;
    typedef enum logic {S_IDLE, S_ACC} state_t;
endpackage

// File: rtl/bitwise_op_core.sv
// bitwise_op_core: combinational (op, a, b) -> result, reusable by the ALU mux
// Ports: op (operation code), a/b (operands), y (result; ACC_OR gives a|b for a single beat)
module bitwise_op_core
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (op_t'(op))
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_NOT_A: y = ~a;
            default:  y = a | b;
        endcase
    end
endmodule

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: pipelined bitwise logic unit with OR-accumulate and result flags
// Ports: clk/rst (sync active-high), in_valid/in_ready/op/a/b/in_last (operand beat),
//        out_valid/out_ready/y/out_zero/out_ones/out_parity/out_beats (registered result)
module bitwise_logic_pipe
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_beats
);
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] beats;
    logic             accept;
    logic             acc_beat;
    logic             emit;

    bitwise_op_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (core_y)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // once a burst is open every beat joins it, regardless of its op
    assign acc_beat = state == S_ACC || op == OP_ACC_OR;
    assign emit     = accept && (!acc_beat || in_last);
    assign cnt_inc  = &cnt ? cnt : cnt + CNT_W'(1);
    assign res      = state == S_ACC ? acc | a | b : core_y;
    assign beats    = state == S_ACC ? cnt_inc : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            y          <= '0;
            out_zero   <= 1'b0;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
            out_beats  <= '0;
        end else begin
            if (emit) begin
                out_valid  <= 1'b1;
                y          <= res;
                out_zero   <= res == '0;
                out_ones   <= &res;
                out_parity <= ^res;
                out_beats  <= beats;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
            if (accept && acc_beat) begin
                state <= in_last ? S_IDLE : S_ACC;
                acc   <= in_last ? '0 : acc | a | b;
                cnt   <= in_last ? '0 : (state == S_ACC ? cnt_inc : CNT_W'(1));
            end
        end
    end
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb_bitwise_logic_pipe: scoreboard bench for bitwise_logic_pipe (8-bit/CNT_W=8 and CNT_W=2 copies)
module tb_bitwise_logic_pipe;
    typedef struct {
        logic [7:0] y;
        int         beats;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic [2:0] op = 0;
    logic [7:0] a = 0;
    logic [7:0] b = 0;
    logic       in_last = 0;
    logic       out_ready = 1;
    logic       in_ready, out_valid, out_zero, out_ones, out_parity;
    logic [7:0] y, out_beats;
    logic       in_ready2, out_valid2, out_zero2, out_ones2, out_parity2;
    logic [7:0] y2;
    logic [1:0] out_beats2;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    bit   rand_rdy = 0;
    bit   m_acc = 0;
    logic [7:0] m_val = 0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity), .out_beats(out_beats)
    );

    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op), .a(a), .b(b),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .out_zero(out_zero2),
        .out_ones(out_ones2), .out_parity(out_parity2), .out_beats(out_beats2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x | z);
            3'd4:    return ~(x & z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x | z;
        endcase
    endfunction

    // reference: a burst is an OR over every beat from its opening ACC_OR up to in_last
    task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic l);
        if (!m_acc && o != 3'd7) begin
            sb.push_back('{ref_op(o, x, z), 1});
        end else begin
            m_val |= x | z;
            m_cnt++;
            if (l) begin
                sb.push_back('{m_val, m_cnt});
                m_acc = 0;
                m_val = 0;
                m_cnt = 0;
            end else begin
                m_acc = 1;
            end
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic l,
                        output int stalls);
        bit ok;
        stalls = 0;
        @(negedge clk);
        in_valid = 1; op = o; a = x; b = z; in_last = l;
        forever begin
            #3 ok = in_ready;
            if (ok) model(o, x, z, l);
            @(posedge clk);
            if (ok) break;
            stalls++;
            if (stalls > 100) begin
                chk("send_timeout", stalls, 0);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_zero"}, out_zero, 0);
        chk({tag, "_ones"}, out_ones, 0);
        chk({tag, "_parity"}, out_parity, 0);
        chk({tag, "_beats"}, out_beats, 0);
    endtask

    initial begin : monitor
        exp_t e;
        bit stall = 0;
        logic [7:0] py = 0;
        logic [7:0] pb = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall = 0;
            end else begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                chk("valid_match", out_valid2, out_valid);
                if (stall && out_valid) begin
                    chk("hold_y", y, py);
                    chk("hold_beats", out_beats, pb);
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("y", y, e.y);
                        chk("zero", out_zero, e.y == 8'h00);
                        chk("ones", out_ones, e.y == 8'hFF);
                        chk("parity", out_parity, ^e.y);
                        chk("beats", out_beats, e.beats > 255 ? 255 : e.beats);
                        chk("y_c2", y2, e.y);
                        chk("beats_c2", out_beats2, e.beats > 3 ? 3 : e.beats);
                    end
                end
                stall = out_valid && !out_ready;
                py = y;
                pb = out_beats;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = $urandom_range(3) != 0;
        end
    end

    initial begin : stim
        int s;
        int tot;
        // a beat offered during reset must be discarded
        in_valid = 1; op = 3'd1; a = 8'h55; b = 8'h0F;
        repeat (3) @(negedge clk);
        #2 chk_reset_vals("rst");
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        send(3'd1, 8'hF0, 8'h0F, 0, s);
        send(3'd2, 8'hA5, 8'hA5, 0, s);
        send(3'd6, 8'h01, 8'h77, 0, s);
        send(3'd0, 8'hC3, 8'h5A, 0, s);
        send(3'd3, 8'h0F, 8'h30, 0, s);
        send(3'd4, 8'hFF, 8'hFF, 0, s);
        send(3'd5, 8'h3C, 8'h0F, 0, s);
        send(3'd7, 8'h12, 8'h40, 1, s);
        // burst whose middle beat carries a non-ACC op
        send(3'd7, 8'h01, 8'h02, 0, s);
        send(3'd0, 8'h04, 8'h00, 0, s);
        send(3'd7, 8'h00, 8'h80, 1, s);
        drain();
        // backpressure: held result, in_ready low, then release with drain+fill
        out_ready = 0;
        send(3'd4, 8'h0F, 8'hF3, 0, s);
        fork
            send(3'd5, 8'h99, 8'h66, 0, s);
            begin
                repeat (4) @(negedge clk);
                out_ready = 1;
            end
        join
        chk("bp_stalls", s, 3);
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(3'($urandom_range(6)), 8'($urandom), 8'($urandom), 0, s);
            tot += s;
        end
        chk("throughput_stalls", tot, 0);
        // saturation: 6 beats (CNT_W=2 copy saturates), then 300 beats (CNT_W=8 saturates)
        for (int i = 0; i < 6; i++) send(3'd7, 8'(1 << (i % 8)), 8'h00, i == 5, s);
        for (int i = 0; i < 300; i++) send(3'd7, 8'h00, (i == 150) ? 8'h20 : 8'h00, i == 299, s);
        drain();
        // reset mid-burst drops the partial accumulation
        send(3'd7, 8'h11, 8'h22, 0, s);
        send(3'd7, 8'h44, 8'h08, 0, s);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #2 chk_reset_vals("midrst");
        @(negedge clk);
        rst = 0;
        m_acc = 0; m_val = 0; m_cnt = 0;
        send(3'd0, 8'hFF, 8'h3C, 0, s);
        drain();
        // random traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send(($urandom_range(3) == 0) ? 3'd7 : 3'($urandom_range(7)),
                 8'($urandom), 8'($urandom), $urandom_range(2) == 0, s);
        end
        send(3'd7, 8'h00, 8'h00, 1, s);
        rand_rdy = 0;
        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
